// File: rtl/alu_iterative_unit.sv
// Multi-cycle ALU responder: ADD/SUB/logic ops in one cycle, shifts one bit per cycle.
// Latency: accept edge -> done cycle is 1 cycle for ops 0-4 and n+1 cycles for a shift by n.
// Backpressure: no queue; start is sampled only while busy=0 and is ignored otherwise.
//
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   start, ALUop, A, B: request strobe, opcode and operands (latched on accept)
//   busy              : high from the accept edge through the done cycle
//   done              : one-cycle pulse; ALUResult/CLFZN update on the edge ending it
//   ALUResult, CLFZN  : registered result and {C,L,F,Z,N} flags, held between ops
module alu_iterative_unit #(
  parameter int WIDTH      = 16,
  parameter int SHAMT_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [4:0]       CLFZN
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [WIDTH-1:0]      work_q, work_d;
  logic [SHAMT_BITS-1:0] count_q, count_d;
  logic                  sc_q, sc_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [4:0]            flags_q, flags_d;

  // Operand-compare flags are shared by every op.
  logic             flag_l, flag_z, flag_n;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] exec_res;
  logic             exec_c, exec_f;
  logic [WIDTH-1:0] shift_val;
  logic             shift_out;

  always_comb begin
    flag_l = (a_q > b_q);
    flag_z = (a_q == b_q);
    flag_n = ($signed(a_q) > $signed(b_q));
    sum    = {1'b0, a_q} + {1'b0, b_q};
    diff   = a_q - b_q;

    exec_res = '0;
    exec_c   = 1'b0;
    exec_f   = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_res = sum[WIDTH-1:0];
        exec_c   = sum[WIDTH];
        exec_f   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res = diff;
        exec_c   = (a_q < b_q);
        exec_f   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      default: exec_res = '0;
    endcase

    // One-bit step of the shifter; the bit falling off the end becomes C.
    shift_val = work_q;
    shift_out = 1'b0;
    case (op_q)
      OP_SLL: begin
        shift_val = {work_q[WIDTH-2:0], 1'b0};
        shift_out = work_q[WIDTH-1];
      end
      OP_SRA: begin
        shift_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        shift_out = work_q[0];
      end
      OP_SRL: begin
        shift_val = {1'b0, work_q[WIDTH-1:1]};
        shift_out = work_q[0];
      end
      default: begin
        shift_val = work_q;
        shift_out = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    count_d  = count_q;
    sc_d     = sc_q;
    result_d = result_q;
    flags_d  = flags_q;
    busy     = (state_q != IDLE);
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = ALUop;
          a_d     = A;
          b_d     = B;
          work_d  = A;
          count_d = B[SHAMT_BITS-1:0];
          // Cleared so a shift by 0 reports C=0.
          sc_d    = 1'b0;
          state_d = (ALUop >= OP_SLL) ? SHIFT : EXEC;
        end
      end
      EXEC: begin
        done     = 1'b1;
        result_d = exec_res;
        flags_d  = {exec_c, flag_l, exec_f, flag_z, flag_n};
        state_d  = IDLE;
      end
      SHIFT: begin
        if (count_q == '0) begin
          done     = 1'b1;
          result_d = work_q;
          flags_d  = {sc_q, flag_l, 1'b0, flag_z, flag_n};
          state_d  = IDLE;
        end else begin
          work_d  = shift_val;
          sc_d    = shift_out;
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      count_q  <= '0;
      sc_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      count_q  <= count_d;
      sc_q     <= sc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign ALUResult = result_q;
  assign CLFZN     = flags_q;

endmodule

// File: tb/tb_alu_iterative_unit.sv
module tb_alu_iterative_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  ALUop;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] ALUResult;
  logic [4:0]  CLFZN;

  int checks;
  int errors;

  alu_iterative_unit #(.WIDTH(16), .SHAMT_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ALUop     (ALUop),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .ALUResult (ALUResult),
    .CLFZN     (CLFZN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a request and wait (bounded) for done; lat counts cycles from the
  // accept edge to the done cycle. Returns while sitting in the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
    ALUop = op;
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic seen_done;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b1;
    ALUop  = 3'd0;
    A      = 16'h1234;
    B      = 16'h0001;

    // Reset held 2 cycles with start=1: nothing accepted.
    tick();
    chk("rst1_busy", busy, 0);
    chk("rst1_done", done, 0);
    chk("rst1_res", ALUResult, 16'h0000);
    chk("rst1_flags", CLFZN, 5'b00000);
    tick();
    chk("rst2_busy", busy, 0);
    chk("rst2_done", done, 0);
    chk("rst2_res", ALUResult, 16'h0000);
    chk("rst2_flags", CLFZN, 5'b00000);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // ADD overflow.
    run_op(3'd0, 16'h7FFF, 16'h0001, lat);
    chk("add_lat", lat, 1);
    chk("add_busy_in_done", busy, 1);
    tick();
    chk("add_res", ALUResult, 16'h8000);
    chk("add_flags", CLFZN, 5'b01101);
    chk("add_busy_after", busy, 0);
    chk("add_done_after", done, 0);

    // SUB borrow; start and operand changes during busy are ignored.
    run_op(3'd4, 16'h0003, 16'h0005, lat);
    chk("sub_lat", lat, 1);
    start = 1'b1;
    A     = 16'hFFFF;
    B     = 16'h0000;
    ALUop = 3'd2;
    tick();
    start = 1'b0;
    chk("sub_res", ALUResult, 16'hFFFE);
    chk("sub_flags", CLFZN, 5'b10000);
    chk("sub_busy_after", busy, 0);
    tick();
    chk("sub_no_accept", busy, 0);

    // SRA by 3: busy 4 cycles, done on the 4th; a start mid-shift is dropped.
    ALUop = 3'd6;
    A     = 16'h8004;
    B     = 16'h0003;
    start = 1'b1;
    tick();
    chk("sra_c1_busy", busy, 1);
    chk("sra_c1_done", done, 0);
    ALUop = 3'd1;
    A     = 16'h0000;
    tick();
    start = 1'b0;
    chk("sra_c2_done", done, 0);
    tick();
    chk("sra_c3_done", done, 0);
    tick();
    chk("sra_c4_done", done, 1);
    chk("sra_c4_busy", busy, 1);
    tick();
    chk("sra_res", ALUResult, 16'hF000);
    chk("sra_flags", CLFZN, 5'b11000);
    chk("sra_busy_after", busy, 0);
    chk("sra_done_after", done, 0);
    tick();
    chk("sra_no_queue", busy, 0);

    // SLL by 0 (upper bits of B ignored).
    run_op(3'd5, 16'h0001, 16'hFFF0, lat);
    chk("sll0_lat", lat, 1);
    tick();
    chk("sll0_res", ALUResult, 16'h0001);
    chk("sll0_flags", CLFZN, 5'b00001);

    // SRL by 15: 16-cycle latency.
    run_op(3'd7, 16'h8000, 16'h000F, lat);
    chk("srl15_lat", lat, 16);
    tick();
    chk("srl15_res", ALUResult, 16'h0001);
    chk("srl15_flags", CLFZN, 5'b01000);

    // Reset on the 3rd cycle of an SLL by 10.
    ALUop = 3'd5;
    A     = 16'h0001;
    B     = 16'h000A;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_busy_before_rst", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_res", ALUResult, 16'h0000);
    chk("mid_rst_flags", CLFZN, 5'b00000);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      tick();
    end
    chk("mid_rst_quiet", seen_done, 0);

    // XOR, then AND accepted on the cycle right after done.
    run_op(3'd3, 16'h00FF, 16'h0F0F, lat);
    chk("xor_lat", lat, 1);
    tick();
    chk("xor_res", ALUResult, 16'h0FF0);
    chk("xor_flags", CLFZN, 5'b00000);
    ALUop = 3'd1;
    A     = 16'hF0F0;
    B     = 16'h3C3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("and_accept_busy", busy, 1);
    chk("and_done", done, 1);
    chk("and_hold_prev", ALUResult, 16'h0FF0);
    tick();
    chk("and_res", ALUResult, 16'h3030);
    chk("and_flags", CLFZN, 5'b01000);
    chk("and_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_iterative_unit.md
Name: alu_iterative_unit

Overview:
- Multi-cycle ALU responder for the CR16 datapath.
- Accepts an operation request from the control or test side over a start/busy/done handshake, computes a result plus CLFZN flags, and holds them until the next request.
- Add and logic ops complete in one cycle. Shifts run one bit per cycle through an internal shifter, so the block needs no barrel shifter.
- Sits between the decode/ALU-control logic and the register-file writeback path.

Parameters:
WIDTH, 16, datapath width of A, B and ALUResult
SHAMT_BITS, 4, number of low bits of B used as the shift amount

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only while busy=0
ALUop  input  3  0 ADD, 1 AND, 2 OR, 3 XOR, 4 SUB, 5 SLL, 6 SRA, 7 SRL
A  input  WIDTH  operand A (shift source)
B  input  WIDTH  operand B; B[SHAMT_BITS-1:0] is the shift amount for ops 5-7
busy  output  1  high from the accept edge until the done cycle, inclusive
done  output  1  one-cycle pulse when ALUResult and CLFZN are valid
ALUResult  output  WIDTH  registered result, held until the next accept
CLFZN  output  5  registered flags {C,L,F,Z,N}, held until the next accept

Behaviour:
- Clock and reset: single clock domain (clk). Reset is synchronous and active-high.
- Reset state:
  - State machine returns to IDLE.
  - busy=0, done=0, ALUResult=0, CLFZN=0.
  - Reset overrides start in the same cycle.
  - Reset mid-shift abandons the operation; no done pulse is produced.
- States:
  - IDLE: busy=0. When start=1, latch A, B and ALUop into op registers and set busy=1.
    - Ops 0-4 go to EXEC.
    - Ops 5-7 go to SHIFT, with count=B[SHAMT_BITS-1:0] and the working register loaded with A.
  - EXEC: compute the result from the latched operands, register ALUResult and CLFZN, pulse done, then go to IDLE.
  - SHIFT:
    - If count==0: register ALUResult from the working register, register CLFZN, pulse done, go to IDLE.
    - Otherwise shift the working register by one bit, capture the bit shifted out as shift-carry, and decrement count.
    - SLL fills with 0. SRL fills with 0. SRA replicates bit WIDTH-1.
- Latency, counted from the accept edge to the edge that registers the result:
  - Ops 0-4: done is asserted in the cycle after accept.
  - Shift by n: n+1 cycles; shift by 0 equals 1 cycle.
  - Next accept is possible in the cycle after done, when busy=0 again.
- Handshake:
  - start while busy=1 is ignored; there is no queue.
  - Operand or ALUop changes after accept have no effect.
  - done is never asserted in two consecutive cycles.
- Arithmetic:
  - ADD is A+B mod 2^WIDTH. SUB is A-B mod 2^WIDTH.
  - Logic ops are bitwise.
  - B[WIDTH-1:SHAMT_BITS] is ignored for shifts.
- Flags, computed from the latched operands for every op:
  - N = signed(A) > signed(B).
  - Z = (A == B).
  - L = unsigned A > unsigned B.
  - F: ADD sets it when A[15]==B[15] and result[15]!=A[15]. SUB sets it when A[15]!=B[15] and result[15]!=A[15]. All other ops give 0.
  - C: ADD gives carry out of bit 15. SUB gives borrow (A<B unsigned). Shifts give the last bit shifted out, or 0 for a shift by 0. Logic ops give 0.
- Holding: ALUResult and CLFZN keep their values while IDLE or between accept and done, and change only on the done cycle.

Test Plan:
- Reset: assert reset for 2 cycles with start=1 -> busy=0, done=0, ALUResult=0, CLFZN=0 throughout, no accept.
- ADD overflow: A=16'h7FFF, B=16'h0001, ALUop=0 -> done 1 cycle after accept; ALUResult=16'h8000; C=0, L=1, F=1, Z=0, N=1.
- SUB borrow: A=3, B=5, ALUop=4 -> ALUResult=16'hFFFE; C=1, L=0, F=0, Z=0, N=0; a second start pulse during busy is ignored.
- SRA timing: A=16'h8004, B=16'h0003, ALUop=6 -> busy for 4 cycles, done on the 4th; ALUResult=16'hF000, C=1.
- Shift width: SLL with A=16'h0001, B=16'hFFF0 (amount 0) -> 1-cycle latency, ALUResult=16'h0001, C=0. SRL with A=16'h8000, B=16'h000F -> ALUResult=16'h0001 after 16 cycles.
- Reset mid-shift and back-to-back: assert reset on the 3rd cycle of an SLL-by-10 -> no done, outputs 0. Then an AND accepted on the cycle after a done -> ALUResult=A&B with no lost request.
